// File: rtl/wb_core_master.sv
// ---------------------------------------------------------------------------
// wb_core_master
//   Bridges the core load/store port onto the pipelined Wishbone bus.
//   Each accepted core request becomes a single Wishbone cycle. Misaligned
//   accesses and reserved sizes are answered immediately with an error
//   response. A bus cycle that stays open for TIMEOUT cycles without an ack
//   is aborted and also answered with an error.
//
// Parameters
//   TIMEOUT  : cycles a bus cycle may stay open (REQ+WAIT), 2..65535
//   ERR_DATA : read data returned with an error response
//
// Ports
//   clk, rst                 : clock, synchronous active-low reset
//   core_req_*               : core request (valid/ready handshake)
//   core_rsp_*               : one-cycle response pulse, no backpressure
//   o_wb_cyc/stb/sel/addr/data, o_re/o_we : registered bus request
//   i_wb_data/ack/stall      : slave response
// ---------------------------------------------------------------------------
module wb_core_master #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req_valid,
    output logic        core_req_ready,
    input  logic        core_req_we,
    input  logic [31:0] core_req_addr,
    input  logic [31:0] core_req_wdata,
    input  logic [1:0]  core_req_size,
    input  logic        core_req_signed,
    output logic        core_rsp_valid,
    output logic [31:0] core_rsp_rdata,
    output logic        core_rsp_err,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic        o_re,
    output logic        o_we,
    input  logic [31:0] i_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    // The abort fires on the edge where the counter would reach TIMEOUT,
    // so the bus cycle is open for exactly TIMEOUT cycles.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] to_cnt;
    logic        we_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;

    logic        accept;
    logic        req_illegal;
    logic        timeout_hit;
    logic [31:0] ack_rdata;

    function automatic logic [3:0] byte_sel(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] sel;
        case (size)
            2'b00:   sel = 4'b0001 << off;
            2'b01:   sel = off[1] ? 4'b1100 : 4'b0011;
            default: sel = 4'b1111;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] wr_lanes(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (size)
            2'b00:   lanes = {4{wdata[7:0]}};
            2'b01:   lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] load_align(input logic [31:0] data, input logic [1:0] size,
                                               input logic [1:0] off, input logic sgn);
        logic [31:0] sh;
        logic [31:0] res;
        sh = data >> {off, 3'b000};
        case (size)
            2'b00:   res = {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   res = {{16{sgn & sh[15]}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    assign accept      = core_req_valid && core_req_ready;
    assign timeout_hit = (to_cnt == TO_LAST);
    assign ack_rdata   = we_q ? 32'h0 : load_align(i_wb_data, size_q, off_q, signed_q);

    always_comb begin
        req_illegal = 1'b0;
        case (core_req_size)
            2'b11:   req_illegal = 1'b1;
            2'b01:   req_illegal = core_req_addr[0];
            2'b10:   req_illegal = (core_req_addr[1:0] != 2'b00);
            default: req_illegal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            core_req_ready <= 1'b0;
            core_rsp_valid <= 1'b0;
            core_rsp_rdata <= 32'h0;
            core_rsp_err   <= 1'b0;
            o_wb_cyc       <= 1'b0;
            o_wb_stb       <= 1'b0;
            o_wb_sel       <= 4'h0;
            o_wb_addr      <= 32'h0;
            o_wb_data      <= 32'h0;
            o_re           <= 1'b0;
            o_we           <= 1'b0;
            to_cnt         <= 16'h0;
            we_q           <= 1'b0;
            signed_q       <= 1'b0;
            size_q         <= 2'b00;
            off_q          <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        core_req_ready <= 1'b0;
                        we_q           <= core_req_we;
                        signed_q       <= core_req_signed;
                        size_q         <= core_req_size;
                        off_q          <= core_req_addr[1:0];
                        if (req_illegal) begin
                            // Answered locally; the bus never sees it.
                            state          <= RESP;
                            core_rsp_valid <= 1'b1;
                            core_rsp_err   <= 1'b1;
                            core_rsp_rdata <= ERR_DATA;
                        end else begin
                            state     <= REQ;
                            o_wb_cyc  <= 1'b1;
                            o_wb_stb  <= 1'b1;
                            o_re      <= !core_req_we;
                            o_we      <= core_req_we;
                            o_wb_sel  <= byte_sel(core_req_size, core_req_addr[1:0]);
                            o_wb_addr <= {core_req_addr[31:2], 2'b00};
                            o_wb_data <= wr_lanes(core_req_size, core_req_wdata);
                            to_cnt    <= 16'h0;
                        end
                    end else begin
                        core_req_ready <= 1'b1;
                    end
                end

                REQ, WAIT: begin
                    // Ack takes priority over both stall and timeout.
                    if (i_wb_ack || timeout_hit) begin
                        state          <= RESP;
                        o_wb_cyc       <= 1'b0;
                        o_wb_stb       <= 1'b0;
                        o_re           <= 1'b0;
                        o_we           <= 1'b0;
                        core_rsp_valid <= 1'b1;
                        core_rsp_err   <= !i_wb_ack;
                        core_rsp_rdata <= i_wb_ack ? ack_rdata : ERR_DATA;
                    end else begin
                        to_cnt <= to_cnt + 16'h1;
                        if (state == REQ && !i_wb_stall) begin
                            state    <= WAIT;
                            o_wb_stb <= 1'b0;
                        end
                    end
                end

                RESP: begin
                    state          <= IDLE;
                    core_req_ready <= 1'b1;
                    core_rsp_valid <= 1'b0;
                    core_rsp_err   <= 1'b0;
                    core_rsp_rdata <= 32'h0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_core_master.sv
module tb_wb_core_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        core_req_valid = 1'b0;
    logic        core_req_ready;
    logic        core_req_we = 1'b0;
    logic [31:0] core_req_addr = 32'h0;
    logic [31:0] core_req_wdata = 32'h0;
    logic [1:0]  core_req_size = 2'b00;
    logic        core_req_signed = 1'b0;
    logic        core_rsp_valid;
    logic [31:0] core_rsp_rdata;
    logic        core_rsp_err;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic        o_re;
    logic        o_we;
    logic [31:0] i_wb_data = 32'h0;
    logic        i_wb_ack = 1'b0;
    logic        i_wb_stall = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected responses: {err, rdata}
    logic [32:0] exp_q[$];

    wb_core_master #(.TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .rst(rst),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_we(core_req_we), .core_req_addr(core_req_addr),
        .core_req_wdata(core_req_wdata), .core_req_size(core_req_size),
        .core_req_signed(core_req_signed),
        .core_rsp_valid(core_rsp_valid), .core_rsp_rdata(core_rsp_rdata),
        .core_rsp_err(core_rsp_err),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_sel(o_wb_sel),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_re(o_re), .o_we(o_we),
        .i_wb_data(i_wb_data), .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Response monitor: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (core_rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'h1, 32'h0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("rsp_rdata", core_rsp_rdata, e[31:0]);
                chk("rsp_err", {31'h0, core_rsp_err}, {31'h0, e[32]});
            end
        end
    end

    // One core transaction. For legal requests the slave stalls `stalls`
    // cycles, then acks in the first WAIT cycle with bus_d.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic sg, input int stalls,
                        input logic [31:0] bus_d, input logic legal,
                        input logic [3:0] e_sel, input logic [31:0] e_addr,
                        input logic [31:0] e_wdat, input logic [31:0] e_rdata,
                        input logic e_err);
        int stb_n;
        exp_q.push_back({e_err, e_rdata});
        @(negedge clk);
        chk("ready_idle", {31'h0, core_req_ready}, 32'h1);
        core_req_valid  = 1'b1;
        core_req_we     = w;
        core_req_addr   = a;
        core_req_wdata  = wd;
        core_req_size   = sz;
        core_req_signed = sg;
        @(negedge clk);
        core_req_valid = 1'b0;
        if (!legal) begin
            chk("illegal_no_cyc", {31'h0, o_wb_cyc}, 32'h0);
        end else begin
            chk("stb_first", {31'h0, o_wb_stb}, 32'h1);
            chk("sel", {28'h0, o_wb_sel}, {28'h0, e_sel});
            chk("addr", o_wb_addr, e_addr);
            chk("wdata", o_wb_data, e_wdat);
            chk("re_we", {30'h0, o_re, o_we}, {30'h0, !w, w});
            stb_n = 0;
            for (int i = 0; i <= stalls; i++) begin
                i_wb_stall = (i < stalls);
                if (o_wb_stb) stb_n++;
                @(negedge clk);
            end
            i_wb_stall = 1'b0;
            chk("stb_cycles", stb_n, stalls + 1);
            chk("wait_cyc_stb", {30'h0, o_wb_cyc, o_wb_stb}, 32'h2);
            chk("sel_stable", {28'h0, o_wb_sel}, {28'h0, e_sel});
            i_wb_ack  = 1'b1;
            i_wb_data = bus_d;
            @(negedge clk);
            i_wb_ack  = 1'b0;
            i_wb_data = 32'h0;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int cyc_n;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'h0, core_req_ready}, 32'h0);
        chk("rst_ctl", {26'h0, o_wb_cyc, o_wb_stb, o_re, o_we, core_rsp_valid, core_rsp_err}, 32'h0);
        chk("rst_sel", {28'h0, o_wb_sel}, 32'h0);
        chk("rst_addr", o_wb_addr, 32'h0);
        chk("rst_data", o_wb_data, 32'h0);
        chk("rst_rdata", core_rsp_rdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'h0, core_req_ready}, 32'h1);

        //    we    addr          wdata         sz     sg  st bus data      legal sel   addr          wdata         rdata         err
        xfer(1'b0, 32'h0000_0010, 32'h0,        2'b10, 0, 0, 32'h8765_4321, 1, 4'hF, 32'h0000_0010, 32'h0,        32'h8765_4321, 0);
        xfer(1'b0, 32'h0000_0013, 32'h0,        2'b00, 1, 0, 32'h80AA_BBCC, 1, 4'h8, 32'h0000_0010, 32'h0,        32'hFFFF_FF80, 0);
        xfer(1'b0, 32'h0000_0013, 32'h0,        2'b00, 0, 0, 32'h80AA_BBCC, 1, 4'h8, 32'h0000_0010, 32'h0,        32'h0000_0080, 0);
        xfer(1'b1, 32'h0000_0022, 32'hFFFF_1234, 2'b01, 0, 3, 32'h5555_5555, 1, 4'hC, 32'h0000_0020, 32'h1234_1234, 32'h0,        0);
        xfer(1'b0, 32'h0000_0006, 32'h0,        2'b10, 0, 0, 32'h0,         0, 4'h0, 32'h0,         32'h0,        32'hDEAD_BEEF, 1);
        xfer(1'b0, 32'h0000_0002, 32'h0,        2'b01, 1, 1, 32'h8001_7FFF, 1, 4'hC, 32'h0000_0000, 32'h0,        32'hFFFF_8001, 0);
        xfer(1'b0, 32'h0000_0101, 32'h0,        2'b00, 0, 0, 32'h1122_3344, 1, 4'h2, 32'h0000_0100, 32'h0,        32'h0000_0033, 0);
        xfer(1'b1, 32'h0000_0005, 32'h0000_00A5, 2'b00, 0, 0, 32'h0,         1, 4'h2, 32'h0000_0004, 32'hA5A5_A5A5, 32'h0,        0);
        xfer(1'b0, 32'h0000_0000, 32'h0,        2'b11, 0, 0, 32'h0,         0, 4'h0, 32'h0,         32'h0,        32'hDEAD_BEEF, 1);
        xfer(1'b1, 32'h0000_0031, 32'h0,        2'b01, 0, 0, 32'h0,         0, 4'h0, 32'h0,         32'h0,        32'hDEAD_BEEF, 1);

        // Timeout: slave never acks
        exp_q.push_back({1'b1, 32'hDEAD_BEEF});
        @(negedge clk);
        chk("ready_before_to", {31'h0, core_req_ready}, 32'h1);
        core_req_valid = 1'b1; core_req_we = 1'b0; core_req_addr = 32'h40;
        core_req_size = 2'b10; core_req_signed = 1'b0;
        @(negedge clk);
        core_req_valid = 1'b0;
        cyc_n = 0;
        for (int i = 0; i < 40 && o_wb_cyc; i++) begin
            cyc_n++;
            @(negedge clk);
        end
        chk("timeout_cyc_len", cyc_n, 8);

        // Next request after timeout proceeds normally
        xfer(1'b0, 32'h0000_0044, 32'h0, 2'b10, 0, 0, 32'h0BAD_F00D, 1, 4'hF, 32'h0000_0044, 32'h0, 32'h0BAD_F00D, 0);

        // Reset while in WAIT: no response, stray ack ignored afterwards
        @(negedge clk);
        core_req_valid = 1'b1; core_req_we = 1'b0; core_req_addr = 32'h8;
        core_req_size = 2'b10;
        @(negedge clk);
        core_req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_wait", {30'h0, o_wb_cyc, o_wb_stb}, 32'h2);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_cyc", {31'h0, o_wb_cyc}, 32'h0);
        chk("midrst_rsp", {31'h0, core_rsp_valid}, 32'h0);
        chk("midrst_ready", {31'h0, core_req_ready}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'h0, core_req_ready}, 32'h1);
        i_wb_ack = 1'b1; i_wb_data = 32'h1234_5678;
        @(negedge clk);
        i_wb_ack = 1'b0; i_wb_data = 32'h0;
        chk("stray_ack_rsp", {31'h0, core_rsp_valid}, 32'h0);
        chk("stray_ack_cyc", {31'h0, o_wb_cyc}, 32'h0);

        xfer(1'b0, 32'h0000_0012, 32'h0, 2'b01, 0, 0, 32'hBEEF_0000, 1, 4'hC, 32'h0000_0010, 32'h0, 32'h0000_BEEF, 0);

        repeat (4) @(negedge clk);
        chk("all_rsp_seen", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
